explosion_sprite_arbiter: RTL and testbench

//  Shares the single-port 3072x8 explosion sprite ROM among NREQ sprite-render requesters.
//  - Arbitration: round-robin with bounded bursts.
//  - Address mapping: {frame, offset} -> ROM address, with a fixed 1-cycle read return.
//  - Placement: between the per-explosion render engines and the sprite ROM.
//  - Stall: ROM clock enable is gated while the frame is frozen.

---
 rtl/explosion_sprite_arbiter.sv | 129 ++++++++++++
 tb/tb_explosion_sprite_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/explosion_sprite_arbiter.sv
// rtl/explosion_sprite_arbiter.sv - round-robin bursting arbiter sharing the explosion sprite ROM
// Optional per-requester statistics outputs: define EXPLOSION_ARB_STATS_EN.
module explosion_sprite_arbiter #(
    parameter int NREQ       = 4,
    parameter int MAX_BURST  = 32,
    parameter int NUM_FRAMES = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               freeze,
    input  logic [NREQ-1:0]    req,
    input  logic [2*NREQ-1:0]  req_frame,
    input  logic [10*NREQ-1:0] req_offset,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rd_valid,
    output logic [7:0]         rd_data,
    output logic [11:0]        rom_address,
    output logic               rom_chipselect,
    output logic               rom_clken,
    input  logic [7:0]         rom_readdata
`ifdef EXPLOSION_ARB_STATS_EN
    ,
    output logic [16*NREQ-1:0] stat_grants,
    output logic [15:0]        stat_stalls
`endif
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic {ARB, BURST} state_t;

    state_t        state, state_n;
    logic [PW-1:0] owner, owner_n;
    logic [PW-1:0] rr_ptr, rr_ptr_n;
    logic [7:0]    burst_cnt, burst_cnt_n;
    logic [PW-1:0] cand, arb_idx, gnt_idx;
    logic          arb_hit, keep, gnt_any, frame_ok, rd_ok_q;
    logic [1:0]    sel_frame;
    logic [9:0]    sel_offset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            rr_ptr    <= rr_ptr_n;
            burst_cnt <= burst_cnt_n;
        end
    end

    // Cyclic search from rr_ptr; after a burst rr_ptr already sits at owner+1.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(rr_ptr) + k) % NREQ);
            if (!arb_hit && req[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
        keep    = (state == BURST) && req[owner] && (burst_cnt < 8'(MAX_BURST));
        gnt_any = !reset && !freeze && (keep || arb_hit);
        gnt_idx = keep ? owner : arb_idx;
    end

    always_comb begin
        state_n     = state;
        owner_n     = owner;
        rr_ptr_n    = rr_ptr;
        burst_cnt_n = burst_cnt;
        if (gnt_any) begin
            state_n     = BURST;
            owner_n     = gnt_idx;
            rr_ptr_n    = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            burst_cnt_n = keep ? burst_cnt + 8'd1 : 8'd1;
        end else if (!freeze) begin
            state_n = ARB;
        end
    end

    always_comb begin
        sel_frame  = '0;
        sel_offset = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == PW'(i)) begin
                sel_frame  = req_frame[2*i +: 2];
                sel_offset = req_offset[10*i +: 10];
            end
        end
        frame_ok       = (32'(sel_frame) < NUM_FRAMES);
        gnt            = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
        rom_address    = gnt_any ? {sel_frame, sel_offset} : 12'h000;
        rom_chipselect = gnt_any && frame_ok;
        rom_clken      = reset || !freeze;
    end

    // ROM q is unregistered, so the palette index lands one cycle after the grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= '0;
            rd_ok_q  <= 1'b0;
        end else begin
            rd_valid <= gnt;
            rd_ok_q  <= rom_chipselect;
        end
    end

    assign rd_data = rd_ok_q ? rom_readdata : 8'h00;

`ifdef EXPLOSION_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_grants <= '0;
            stat_stalls <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) stat_grants[16*i +: 16] <= stat_grants[16*i +: 16] + 16'd1;
            end
            if (|req && !gnt_any && stat_stalls != 16'hFFFF) stat_stalls <= stat_stalls + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_explosion_sprite_arbiter.sv
// tb/tb_explosion_sprite_arbiter.sv - directed plus randomized check of explosion_sprite_arbiter
module tb_explosion_sprite_arbiter;
    localparam int NREQ       = 4;
    localparam int MAX_BURST  = 4;
    localparam int NUM_FRAMES = 3;

    logic                 clk = 1'b0;
    logic                 reset, freeze;
    logic [NREQ-1:0]      req;
    logic [2*NREQ-1:0]    req_frame;
    logic [10*NREQ-1:0]   req_offset;
    logic [NREQ-1:0]      gnt, rd_valid;
    logic [7:0]           rd_data, rom_readdata;
    logic [11:0]          rom_address;
    logic                 rom_chipselect, rom_clken;
    logic [11:0]          rom_addr_q = 12'h000;
`ifdef EXPLOSION_ARB_STATS_EN
    logic [16*NREQ-1:0]   stat_grants;
    logic [15:0]          stat_stalls;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit   m_burst;
    int   m_owner, m_run, m_ptr, m_last_g, p_idx;
    logic [7:0] p_data;

    explosion_sprite_arbiter #(
        .NREQ(NREQ), .MAX_BURST(MAX_BURST), .NUM_FRAMES(NUM_FRAMES)
    ) dut (
        .clk(clk), .reset(reset), .freeze(freeze), .req(req),
        .req_frame(req_frame), .req_offset(req_offset),
        .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .rom_address(rom_address), .rom_chipselect(rom_chipselect),
        .rom_clken(rom_clken), .rom_readdata(rom_readdata)
`ifdef EXPLOSION_ARB_STATS_EN
        , .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_word(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h3C;
    endfunction

    always @(posedge clk) if (rom_clken) rom_addr_q <= rom_address;
    assign rom_readdata = rom_word(rom_addr_q);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    // Predict this cycle from the arbitration rules, compare, then advance the model.
    task automatic fin();
        int g;
        bit kept, ok;
        logic [1:0] fr;
        logic [9:0] off;
        g = -1; kept = 0; ok = 0; fr = '0; off = '0;
        if (!reset && !freeze) begin
            if (m_burst && req[m_owner] && m_run < MAX_BURST) begin
                g = m_owner;
                kept = 1;
            end else begin
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && req[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        check("gnt", gnt, (g >= 0) ? (32'd1 << g) : 32'd0);
        if (g >= 0) begin
            fr  = req_frame[2*g +: 2];
            off = req_offset[10*g +: 10];
            ok  = (fr < NUM_FRAMES);
            check("rom_chipselect", rom_chipselect, ok);
            if (ok) check("rom_address", rom_address, {fr, off});
        end else begin
            check("rom_chipselect", rom_chipselect, 0);
        end
        check("rd_valid", rd_valid, (p_idx >= 0) ? (32'd1 << p_idx) : 32'd0);
        check("rd_data", rd_data, (p_idx >= 0) ? p_data : 8'h00);
        check("rom_clken", rom_clken, reset || !freeze);
        m_last_g = g;
        if (reset) begin
            m_burst = 0; m_owner = 0; m_run = 0; m_ptr = 0; p_idx = -1;
        end else begin
            p_idx  = g;
            p_data = ok ? rom_word({fr, off}) : 8'h00;
            if (g >= 0) begin
                m_run   = kept ? m_run + 1 : 1;
                m_owner = g;
                m_ptr   = (g + 1) % NREQ;
                m_burst = 1;
            end else if (!freeze) begin
                m_burst = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        half();
        fin();
    endtask

    task automatic set_req(input int i, input logic [1:0] fr, input logic [9:0] off);
        req_frame[2*i +: 2]   = fr;
        req_offset[10*i +: 10] = off;
    endtask

    initial begin
        m_burst = 0; m_owner = 0; m_run = 0; m_ptr = 0; m_last_g = -1; p_idx = -1; p_data = 8'h00;
        reset = 1'b1; freeze = 1'b0; req = '0; req_frame = '0; req_offset = '0;
        @(posedge clk); #1;
        tick(); tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            half();
            check("idle_gnt", gnt, 0);
            check("idle_rd_data", rd_data, 8'h00);
            fin();
        end

        // Single read of frame 1, offset 5
        req = 4'b0001; set_req(0, 2'd1, 10'h005);
        half();
        check("first_gnt", gnt, 4'b0001);
        check("first_addr", rom_address, 12'h405);
        fin();
        req = '0;
        half();
        check("first_rd_valid", rd_valid, 4'b0001);
        check("first_rd_data", rd_data, rom_word(12'h405));
        fin();

        // Two continuous requesters: bursts of MAX_BURST alternate
        reset = 1'b1; tick(); reset = 1'b0;
        req = 4'b0101;
        for (int c = 0; c < 12; c++) begin
            set_req(0, 2'd0, 10'(c)); set_req(2, 2'd2, 10'(c + 100));
            half();
            check("burst_pattern", gnt, ((c / MAX_BURST) % 2 == 0) ? 4'b0001 : 4'b0100);
            fin();
        end
        req = '0; tick();

        // Out-of-range frame: granted, ROM deselected, transparent pixel
        req = 4'b0010; set_req(1, 2'd3, 10'h123);
        half();
        check("bad_frame_gnt", gnt, 4'b0010);
        check("bad_frame_cs", rom_chipselect, 0);
        fin();
        req = '0;
        half();
        check("bad_frame_rd_valid", rd_valid, 4'b0010);
        check("bad_frame_rd_data", rd_data, 8'h00);
        fin();

        // Freeze mid-burst keeps burst_cnt: two grants, freeze, two more, then requester 1
        req = 4'b0011; set_req(0, 2'd2, 10'h3A7); set_req(1, 2'd0, 10'h011);
        tick(); tick();
        freeze = 1'b1;
        half();
        check("freeze_no_gnt", gnt, 0);
        check("freeze_rd_valid", rd_valid, 4'b0001);
        check("freeze_rd_data", rd_data, rom_word(12'hBA7));
        fin();
        tick();
        freeze = 1'b0;
        for (int c = 0; c < 3; c++) begin
            half();
            check("resume_pattern", gnt, (c < 2) ? 4'b0001 : 4'b0010);
            fin();
        end

        // Reset mid-burst
        tick();
        reset = 1'b1;
        half();
        check("reset_gnt", gnt, 0);
        fin();
        reset = 1'b0; req = 4'b0110;
        half();
        check("post_reset_rd_valid", rd_valid, 0);
        check("post_reset_gnt", gnt, 4'b0010);
        fin();

        // Randomized traffic honouring the requester contract
        req = '0;
        for (int c = 0; c < 3000; c++) begin
            reset  = ($urandom_range(0, 199) == 0);
            freeze = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (m_last_g == i) begin
                    req[i] = ($urandom_range(0, 3) != 0);
                    set_req(i, 2'($urandom_range(0, 3)), 10'($urandom));
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    set_req(i, 2'($urandom_range(0, 3)), 10'($urandom));
                end
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
